// File: rtl/slow_mem_pkg.sv
// Shared types and default constants for the slow off-chip line memory.
// Imported by slow_mem and slow_mem_array.
package slow_mem_pkg;

    localparam int MEM_NUM_D   = 256;
    localparam int MEM_WIDTH_D = 128;
    localparam int LATENCY_D   = 15;
    localparam int LINE_ADDR_W = 28;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        READY = 2'd2,
        TURN  = 2'd3
    } state_t;

    // Request captured at acceptance; rd is kept only for protocol checking.
    typedef struct packed {
        logic                   rd;
        logic                   wr;
        logic [LINE_ADDR_W-1:0] addr;
    } req_t;

endpackage

// File: rtl/slow_mem_array.sv
// Line storage for slow_mem: synchronous write port, registered read port.
// `mem` is left unreset so it can be preloaded hierarchically (u_array.mem).
module slow_mem_array
    import slow_mem_pkg::*;
#(
    parameter int MEM_NUM   = MEM_NUM_D,
    parameter int MEM_WIDTH = MEM_WIDTH_D
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_we,
    input  logic                       i_re,
    input  logic [$clog2(MEM_NUM)-1:0] i_idx,
    input  logic [MEM_WIDTH-1:0]       i_wdata,
    output logic [MEM_WIDTH-1:0]       o_rdata
);

    logic [MEM_WIDTH-1:0] mem [0:MEM_NUM-1];
    logic [MEM_WIDTH-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) mem[i_idx] <= i_wdata;
    end

    // Read data is held until the next read; writes never disturb it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    r_rdata <= '0;
        else if (i_re) r_rdata <= mem[i_idx];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/slow_mem.sv
// Fixed-latency slow line memory: request accepted in IDLE, ready pulse LATENCY
// cycles later, one dead cycle after. Define SLOW_MEM_CHECK_EN for the protocol checker.
module slow_mem
    import slow_mem_pkg::*;
#(
    parameter int MEM_NUM   = MEM_NUM_D,
    parameter int MEM_WIDTH = MEM_WIDTH_D,
    parameter int LATENCY   = LATENCY_D
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   mem_read,
    input  logic                   mem_write,
    input  logic [LINE_ADDR_W-1:0] mem_addr,
    input  logic [MEM_WIDTH-1:0]   mem_wdata,
    output logic [MEM_WIDTH-1:0]   mem_rdata,
    output logic                   mem_ready
);

    localparam int IDX_W = $clog2(MEM_NUM);
    localparam int CNT_W = (LATENCY > 2) ? $clog2(LATENCY) : 1;
    // Outputs are registered on leaving READY, so READY is entered one cycle early.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((LATENCY >= 2) ? LATENCY - 2 : 0);

    state_t               r_state, w_state_nxt;
    logic [CNT_W-1:0]     r_cnt;
    req_t                 r_req;
    logic [MEM_WIDTH-1:0] r_wdata;
    logic                 r_ready;
    logic                 w_accept, w_we, w_re, w_ready_nxt;
    logic [IDX_W-1:0]     w_idx;

    assign w_accept = (r_state == IDLE) && (mem_read || mem_write);
    assign w_idx    = r_req.addr[IDX_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_nxt = (LATENCY == 1) ? READY : BUSY;
            BUSY:    if (r_cnt == CNT_LAST) w_state_nxt = READY;
            READY:   w_state_nxt = TURN;
            TURN:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_we        = 1'b0;
        w_re        = 1'b0;
        w_ready_nxt = 1'b0;
        if (r_state == READY) begin
            w_ready_nxt = 1'b1;
            w_we        = r_req.wr;
            w_re        = !r_req.wr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_req   <= '0;
            r_wdata <= '0;
            r_ready <= 1'b0;
        end else begin
            r_ready <= w_ready_nxt;
            if (w_accept) begin
                r_cnt      <= '0;
                r_req.rd   <= mem_read;
                r_req.wr   <= mem_write;
                r_req.addr <= mem_addr;
                r_wdata    <= mem_wdata;
            end else if (r_state == BUSY) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    slow_mem_array #(
        .MEM_NUM   (MEM_NUM),
        .MEM_WIDTH (MEM_WIDTH)
    ) u_array (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_we    (w_we),
        .i_re    (w_re),
        .i_idx   (w_idx),
        .i_wdata (r_wdata),
        .o_rdata (mem_rdata)
    );

    assign mem_ready = r_ready;

`ifdef SLOW_MEM_CHECK_EN
    logic r_proto_err;
    logic w_err_both, w_err_busy, w_err_alias;

    always_comb begin
        w_err_both  = w_accept && mem_read && mem_write;
        w_err_alias = w_accept && (mem_addr >= LINE_ADDR_W'(MEM_NUM));
        w_err_busy  = (r_state == BUSY) &&
                      ((mem_read != r_req.rd) || (mem_write != r_req.wr) ||
                       (mem_addr != r_req.addr));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_proto_err <= 1'b0;
        else if (w_err_both || w_err_busy || w_err_alias) r_proto_err <= 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (w_err_both)  $error("slow_mem: read and write requested together");
            if (w_err_busy)  $error("slow_mem: request or address changed while busy");
            if (w_err_alias) $error("slow_mem: address %0h beyond %0d lines", mem_addr, MEM_NUM);
        end
    end
`else
    logic w_unused;
    assign w_unused = ^{r_req.rd, r_req.addr[LINE_ADDR_W-1:IDX_W]};
`endif

endmodule

// File: tb/tb_slow_mem.sv
// Scoreboard bench for slow_mem: expected read data queued at issue, compared on ready.
module tb_slow_mem;

    localparam int LAT = 15;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         mem_read, mem_write;
    logic [27:0]  mem_addr;
    logic [127:0] mem_wdata, mem_rdata;
    logic         mem_ready;

    int n_chk = 0, n_fail = 0;
    int cyc = 0, n_rdy = 0;
    logic [127:0] model [0:255];
    logic [127:0] exp_q [$];
    logic [127:0] last_rd = '0;

    slow_mem #(.MEM_NUM(256), .MEM_WIDTH(128), .LATENCY(LAT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (mem_ready) n_rdy <= n_rdy + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Waits (bounded) for the next ready pulse, sampled on the falling edge.
    task automatic wait_rdy(output int t);
        t = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (mem_ready) begin
                t = cyc;
                return;
            end
        end
        check("ready_timeout", 128'(0), 128'(1));
    endtask

    task automatic on_ready(input logic is_rd);
        logic [127:0] e;
        if (is_rd) begin
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
            check("rdata", mem_rdata, e);
            last_rd = e;
        end else begin
            check("rdata_held", mem_rdata, last_rd);
        end
    endtask

    // Called at a falling edge with the DUT idle; returns at a falling edge.
    task automatic do_op(input logic rd, input logic wr, input logic [27:0] addr,
                         input logic [127:0] wd, input bit hold, output int lat);
        int t_acc, t_rdy;
        mem_read = rd; mem_write = wr; mem_addr = addr; mem_wdata = wd;
        if (wr) model[addr[7:0]] = wd;
        else    exp_q.push_back(model[addr[7:0]]);
        @(posedge clk);
        @(negedge clk);
        t_acc = cyc;
        wait_rdy(t_rdy);
        on_ready(!wr);
        if (hold) @(negedge clk);
        mem_read = 1'b0; mem_write = 1'b0;
        mem_addr = $urandom; mem_wdata = {4{$urandom}};
        @(negedge clk);
        lat = (t_rdy < 0) ? -1 : t_rdy - t_acc;
    endtask

    initial begin
        int lat, t0, t1, t2, r0;
        rst_n = 1'b0; mem_read = 1'b0; mem_write = 1'b0; mem_addr = '0; mem_wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", 128'(mem_ready), 128'(0));
        check("rst_rdata", mem_rdata, 128'(0));
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", 128'(mem_ready), 128'(0));

        // Preload line 5, then read it holding the request one extra cycle.
        do_op(1'b0, 1'b1, 28'd5, 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF, 1'b0, lat);
        check("wr_latency", 128'(lat), 128'(LAT));
        do_op(1'b1, 1'b0, 28'd5, '0, 1'b1, lat);
        check("rd_latency", 128'(lat), 128'(LAT));
        r0 = n_rdy;
        repeat (25) @(negedge clk);
        check("no_reaccept", 128'(n_rdy - r0), 128'(0));

        // Write then read line 9; the write must not touch rdata.
        do_op(1'b0, 1'b1, 28'd9, 128'h01234567_89ABCDEF_01234567_89ABCDEF, 1'b0, lat);
        do_op(1'b1, 1'b0, 28'd9, '0, 1'b0, lat);
        check("rd9_latency", 128'(lat), 128'(LAT));

        // Back-to-back reads of lines 0 and 1 with the request held high.
        do_op(1'b0, 1'b1, 28'd0, 128'hA0A0_0000_1111_2222_3333_4444_5555_0A0A, 1'b0, lat);
        do_op(1'b0, 1'b1, 28'd1, 128'hB1B1_6666_7777_8888_9999_AAAA_BBBB_1B1B, 1'b0, lat);
        mem_read = 1'b1; mem_addr = 28'd0;
        exp_q.push_back(model[0]);
        @(posedge clk);
        @(negedge clk);
        t0 = cyc;
        wait_rdy(t1);
        on_ready(1'b1);
        exp_q.push_back(model[1]);
        mem_addr = 28'd1;
        wait_rdy(t2);
        on_ready(1'b1);
        mem_read = 1'b0;
        @(negedge clk);
        check("b2b_first_lat", 128'(t1 - t0), 128'(LAT));
        check("b2b_period", 128'(t2 - t1), 128'(LAT + 2));

        // Aliased address with read and write both high acts as a write to line 3.
        mem_read = 1'b1; mem_write = 1'b1; mem_addr = 28'd259;
        mem_wdata = 128'hC3C3_C3C3_0000_FFFF_1234_5678_9ABC_DEF0;
        model[3] = mem_wdata;
        @(posedge clk);
        @(negedge clk);
        t0 = cyc;
        wait_rdy(t1);
        on_ready(1'b0);
        mem_read = 1'b0; mem_write = 1'b0;
        @(negedge clk);
        check("alias_latency", 128'(t1 - t0), 128'(LAT));
        do_op(1'b1, 1'b0, 28'd3, '0, 1'b0, lat);
        do_op(1'b1, 1'b0, 28'd259, '0, 1'b0, lat);

        // Reset in the middle of a write to line 2 must leave line 2 intact.
        do_op(1'b0, 1'b1, 28'd2, 128'h2222_0000_2222_0000_2222_0000_2222_0000, 1'b0, lat);
        mem_write = 1'b1; mem_addr = 28'd2; mem_wdata = 128'hBAD0_BAD0_BAD0_BAD0_BAD0_BAD0_BAD0_BAD0;
        @(posedge clk);
        repeat (7) @(posedge clk);
        #1 rst_n = 1'b0;
        mem_write = 1'b0;
        @(negedge clk);
        check("abort_ready", 128'(mem_ready), 128'(0));
        check("abort_rdata", mem_rdata, 128'(0));
        check("abort_state", 128'(dut.r_state), 128'(0));
        last_rd = '0;
        r0 = n_rdy;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("abort_no_ready", 128'(n_rdy - r0), 128'(0));
        do_op(1'b1, 1'b0, 28'd2, '0, 1'b0, lat);
        do_op(1'b1, 1'b0, 28'd9, '0, 1'b0, lat);

        check("scoreboard_empty", 128'(exp_q.size()), 128'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
